shared_mem_arb_2port: RTL and testbench

Parameterised on-chip shared memory for the MPSoC with two independent Avalon-MM slave ports (s1, s2), one per processor. Both ports share one single-port RAM through a round-robin arbiter. The block adds waitrequest back-pressure, pipelined reads with readdatavalid, and a per-port lock that holds the grant for atomic read-modify-write. It sits on the system interconnect as the inter-processor mailbox/data store.

---
 rtl/shared_mem_arb_2port.sv | 158 +++++++++++++++
 tb/tb_shared_mem_arb_2port.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arb_2port.sv
// Two-port Avalon-MM shared memory: one single-port RAM behind a round-robin
// arbiter with per-port grant lock and tagged, pipelined read return.
module shared_mem_arb_2port #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter int BE_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [BE_WIDTH-1:0]   s1_byteenable,
  input  logic [DATA_WIDTH-1:0] s1_writedata,
  input  logic                  s1_lock,
  output logic [DATA_WIDTH-1:0] s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0] s2_address,
  input  logic                  s2_chipselect,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [BE_WIDTH-1:0]   s2_byteenable,
  input  logic [DATA_WIDTH-1:0] s2_writedata,
  input  logic                  s2_lock,
  output logic [DATA_WIDTH-1:0] s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_waitrequest
);

  typedef enum logic [1:0] {
    LOCK_NONE,
    LOCK_S1,
    LOCK_S2
  } lock_t;

  lock_t lock_q, lock_d;
  logic  last_s2_q, last_s2_d;

  logic req1, req2, grant1, grant2, acc1, acc2;
  logic acc, acc_write, acc_read;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   be;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic                  ret_valid;
  logic                  ret_port;
  logic [DATA_WIDTH-1:0] ret_data;

  always_comb begin
    req1 = s1_chipselect & (s1_read | s1_write);
    req2 = s2_chipselect & (s2_read | s2_write);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= LOCK_NONE;
      last_s2_q <= 1'b1;
    end else begin
      lock_q    <= lock_d;
      last_s2_q <= last_s2_d;
    end
  end

  // A lock owner keeps the grant even while idle; no grants during reset.
  always_comb begin
    grant1    = 1'b0;
    grant2    = 1'b0;
    lock_d    = lock_q;
    last_s2_d = last_s2_q;
    if (!reset) begin
      unique case (lock_q)
        LOCK_S1: grant1 = req1;
        LOCK_S2: grant2 = req2;
        default: begin
          if (req1 && req2) begin
            grant1 = last_s2_q;
            grant2 = ~last_s2_q;
          end else begin
            grant1 = req1;
            grant2 = req2;
          end
        end
      endcase
    end
    acc1 = req1 & grant1;
    acc2 = req2 & grant2;
    if (acc1) begin
      last_s2_d = 1'b0;
      lock_d    = s1_lock ? LOCK_S1 : LOCK_NONE;
    end else if (acc2) begin
      last_s2_d = 1'b1;
      lock_d    = s2_lock ? LOCK_S2 : LOCK_NONE;
    end
  end

  assign s1_waitrequest = reset | (req1 & ~grant1);
  assign s2_waitrequest = reset | (req2 & ~grant2);

  always_comb begin
    addr      = acc2 ? s2_address    : s1_address;
    wdata     = acc2 ? s2_writedata  : s1_writedata;
    be        = acc2 ? s2_byteenable : s1_byteenable;
    acc       = acc1 | acc2;
    acc_write = acc2 ? s2_write : s1_write;
    acc_read  = acc & ~acc_write;
  end

  always_ff @(posedge clk) begin
    if (acc && acc_write) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      always_comb begin
        ret_valid = acc_read;
        ret_port  = acc2;
        ret_data  = mem[addr];
      end
    end else begin : g_lat2
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ret_valid <= 1'b0;
          ret_port  <= 1'b0;
          ret_data  <= '0;
        end else begin
          ret_valid <= acc_read;
          ret_port  <= acc2;
          ret_data  <= mem[addr];
        end
      end
    end
  endgenerate

  // Port tag steers the returning word; readdata holds between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_readdatavalid <= 1'b0;
      s2_readdatavalid <= 1'b0;
      s1_readdata      <= '0;
      s2_readdata      <= '0;
    end else begin
      s1_readdatavalid <= ret_valid & ~ret_port;
      s2_readdatavalid <= ret_valid & ret_port;
      if (ret_valid && !ret_port) s1_readdata <= ret_data;
      if (ret_valid && ret_port)  s2_readdata <= ret_data;
    end
  end

endmodule

// File: tb/tb_shared_mem_arb_2port.sv
// Randomized bench for shared_mem_arb_2port: latency-1 and latency-2 builds
// share one stimulus stream and are checked against a transaction-level model.
module tb_shared_mem_arb_2port;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:1]         cs, rd, wr, lk;
  logic [2:1][AW-1:0] ad;
  logic [2:1][BW-1:0] be;
  logic [2:1][DW-1:0] wd;

  logic [1:0][2:1]         rdv, wrq;
  logic [1:0][2:1][DW-1:0] rdd;

  shared_mem_arb_2port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .s1_address(ad[1]), .s1_chipselect(cs[1]), .s1_read(rd[1]), .s1_write(wr[1]),
    .s1_byteenable(be[1]), .s1_writedata(wd[1]), .s1_lock(lk[1]),
    .s1_readdata(rdd[0][1]), .s1_readdatavalid(rdv[0][1]), .s1_waitrequest(wrq[0][1]),
    .s2_address(ad[2]), .s2_chipselect(cs[2]), .s2_read(rd[2]), .s2_write(wr[2]),
    .s2_byteenable(be[2]), .s2_writedata(wd[2]), .s2_lock(lk[2]),
    .s2_readdata(rdd[0][2]), .s2_readdatavalid(rdv[0][2]), .s2_waitrequest(wrq[0][2])
  );

  shared_mem_arb_2port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset),
    .s1_address(ad[1]), .s1_chipselect(cs[1]), .s1_read(rd[1]), .s1_write(wr[1]),
    .s1_byteenable(be[1]), .s1_writedata(wd[1]), .s1_lock(lk[1]),
    .s1_readdata(rdd[1][1]), .s1_readdatavalid(rdv[1][1]), .s1_waitrequest(wrq[1][1]),
    .s2_address(ad[2]), .s2_chipselect(cs[2]), .s2_read(rd[2]), .s2_write(wr[2]),
    .s2_byteenable(be[2]), .s2_writedata(wd[2]), .s2_lock(lk[2]),
    .s2_readdata(rdd[1][2]), .s2_readdatavalid(rdv[1][2]), .s2_waitrequest(wrq[1][2])
  );

  typedef struct {
    int            e;
    int            port;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0]           mmem [DEPTH];
  rd_t                     q[$];
  int                      owner, last, ecur;
  bit [2:1]                mreq, mg, macc;
  logic [1:0][2:1][DW-1:0] exp_rd;
  int                      n_cmp = 0;
  int                      n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Negedge: predict grants from the arbitration rules and compare outputs.
  task automatic sample();
    @(negedge clk);
    if (reset) begin
      owner  = 0;
      last   = 2;
      q.delete();
      exp_rd = '0;
    end
    for (int p = 1; p <= 2; p++) mreq[p] = cs[p] & (rd[p] | wr[p]);
    mg = '0;
    if (!reset) begin
      if (owner != 0) mg[owner] = mreq[owner];
      else if (mreq == 2'b11) mg[(last == 2) ? 1 : 2] = 1'b1;
      else mg = mreq;
    end
    for (int l = 0; l < 2; l++) begin
      bit [2:1] ev;
      ev = '0;
      foreach (q[i]) begin
        if (q[i].e == ecur - l) begin
          ev[q[i].port]          = 1'b1;
          exp_rd[l][q[i].port]   = q[i].data;
        end
      end
      for (int p = 1; p <= 2; p++) begin
        check($sformatf("L%0d_s%0d_waitrequest", l + 1, p), wrq[l][p],
              reset | (mreq[p] & ~mg[p]));
        check($sformatf("L%0d_s%0d_readdatavalid", l + 1, p), rdv[l][p], ev[p]);
        check($sformatf("L%0d_s%0d_readdata", l + 1, p), rdd[l][p], exp_rd[l][p]);
      end
    end
  endtask

  // Posedge: apply the accepted transfer to the model.
  task automatic update();
    @(posedge clk);
    ecur++;
    macc = '0;
    if (!reset) begin
      for (int p = 1; p <= 2; p++) begin
        if (mg[p]) begin
          macc[p] = 1'b1;
          last    = p;
          owner   = lk[p] ? p : 0;
          if (wr[p]) begin
            for (int b = 0; b < BW; b++)
              if (be[p][b]) mmem[ad[p]][8*b +: 8] = wd[p][8*b +: 8];
          end else begin
            q.push_back('{ecur, p, mmem[ad[p]]});
          end
        end
      end
    end
    while (q.size() > 0 && q[0].e < ecur - 1) void'(q.pop_front());
    #1;
  endtask

  task automatic step();
    sample();
    update();
  endtask

  task automatic drive(input int p, input bit c, input bit r, input bit w, input int a,
                       input logic [BW-1:0] b, input logic [DW-1:0] d, input bit l);
    cs[p] = c; rd[p] = r; wr[p] = w; ad[p] = a[AW-1:0];
    be[p] = b; wd[p] = d; lk[p] = l;
  endtask

  task automatic idle(input int p);
    drive(p, 0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic rand_port(input int p);
    bit w;
    w = 1'($urandom_range(0, 1));
    drive(p, $urandom_range(0, 9) < 7, !w || ($urandom_range(0, 19) == 0), w,
          $urandom_range(0, DEPTH - 1), BW'($urandom), $urandom,
          $urandom_range(0, 4) == 0);
  endtask

  initial begin
    owner = 0; last = 2; ecur = 0; mreq = '0; mg = '0; macc = '0; exp_rd = '0;
    foreach (mmem[i]) mmem[i] = '0;
    reset = 1'b1;
    idle(1); idle(2);
    step(); step();
    reset = 1'b0;
    step();

    // Fill every word so later reads compare against known contents.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 1, 0, 1, a, '1, $urandom, 0);
      step();
    end
    idle(1);

    // Write on s1, read back on s2.
    drive(1, 1, 0, 1, 5, 4'hF, 32'hDEADBEEF, 0); step(); idle(1);
    drive(2, 1, 1, 0, 5, '0, '0, 0); step(); idle(2);
    step(); step();
    check("l1_s2_rd_deadbeef", rdd[0][2], 32'hDEADBEEF);
    check("l2_s2_rd_deadbeef", rdd[1][2], 32'hDEADBEEF);

    // Partial byte-lane write.
    drive(1, 1, 0, 1, 7, 4'hF, 32'h11223344, 0); step(); idle(1);
    drive(2, 1, 0, 1, 7, 4'b0101, 32'hAABBCCDD, 0); step(); idle(2);
    drive(1, 1, 1, 0, 7, '0, '0, 0); step(); idle(1);
    step(); step();
    check("l1_partial_write", rdd[0][1], 32'h11BB33DD);
    check("l2_partial_write", rdd[1][1], 32'h11BB33DD);

    // Continuous contention: grants alternate.
    drive(1, 1, 1, 0, 2, '0, '0, 0);
    drive(2, 1, 1, 0, 3, '0, '0, 0);
    for (int i = 0; i < 6; i++) step();
    idle(1); idle(2);
    step(); step();

    // Lock held across idle cycles while s2 keeps requesting.
    drive(1, 1, 1, 0, 3, '0, '0, 1); step(); idle(1);
    drive(2, 1, 1, 0, 3, '0, '0, 0); step(); step();
    drive(1, 1, 0, 1, 3, 4'hF, 32'h5A5AA5A5, 0); step(); idle(1);
    step(); idle(2);
    step(); step();
    check("l1_lock_rmw_value", rdd[0][2], 32'h5A5AA5A5);
    check("l2_lock_rmw_value", rdd[1][2], 32'h5A5AA5A5);

    // Back-to-back reads on one port.
    for (int a = 0; a < 3; a++) begin
      drive(1, 1, 1, 0, a, '0, '0, 0);
      step();
    end
    idle(1);
    step(); step(); step();

    // Reset with reads in flight and a lock held.
    drive(1, 1, 1, 0, 4, '0, '0, 0); step(); idle(1);
    drive(2, 1, 1, 0, 6, '0, '0, 1); step(); idle(2);
    reset = 1'b1; step();
    reset = 1'b0; step();
    drive(1, 1, 1, 0, 5, '0, '0, 0); step(); idle(1);
    step(); step();
    check("l1_post_reset_data", rdd[0][1], 32'hDEADBEEF);
    check("l2_post_reset_data", rdd[1][1], 32'hDEADBEEF);

    // Random traffic; stalled masters hold their request.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 1; p <= 2; p++)
        if (!(mreq[p] && !macc[p])) rand_port(p);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle(1); idle(2);
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
